fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the 5-stage pipeline. Owns the PC register and computes the next PC from sequential, branch, jump, call and return redirects resolved in ID.
- Includes a small return address stack (RAS) for CALL/RET.
- Drives instruction-memory address and the IF_ID register controls (instruction, NPC, kill, disable).
- Has a HALT state entered on a decoded halt.

Parameters:
- PC_W, 32, PC/address width (word-addressed; NPC = PC+1)
- RAS_DEPTH, 8, RAS entries (power of two, >=2)
- RESET_PC, 32'd0, PC value after reset and on RAS underflow

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- stall  in  1  hazard stall from ID: hold PC, hold IF_ID, ignore ID redirects this cycle
- branch_taken_D  in  1  conditional branch resolved taken in ID
- branch_target_D  in  PC_W  branch target
- jump_D  in  1  unconditional jump in ID
- call_D  in  1  CALL in ID (jump + push)
- jump_target_D  in  PC_W  target for jump_D/call_D
- ret_D  in  1  RET in ID (pop RAS, redirect)
- NPC_D  in  PC_W  PC+1 of ID instruction; return address pushed on call_D
- halt_D  in  1  halt decoded in ID
- imem_addr  out  PC_W  = PC register (async-read instruction memory)
- imem_data  in  32  instruction word at imem_addr
- Instruction_F  out  32  = imem_data
- NPC_F  out  PC_W  = PC+1 (wraps modulo 2^PC_W)
- kill  out  1  IF_ID loads NOP (32'h00000000)
- disable_IR  out  1  IF_ID holds (= stall)
- ras_overflow  out  1  sticky: push while full
- ras_underflow  out  1  sticky: pop while empty

Behaviour:
- States: RUN, HALT. Reset to RUN. Synchronous rst has priority over all other inputs.
- Reset values: PC=RESET_PC, RAS ptr=0, count=0, ras_overflow=0, ras_underflow=0, state=RUN.
- While rst=1: kill=1 and disable_IR=0, so IF_ID flushes.
- RUN, stall=1:
  - PC holds; disable_IR=1; kill=0.
  - All D-stage redirect, RAS and halt inputs are ignored, because the ID instruction is re-presented next cycle.
- RUN, stall=0, redirect priority (one redirect per cycle):
  1. halt_D: PC holds, kill=1, next state HALT.
  2. ret_D: PC <= RAS top, pop, kill=1.
  3. call_D: PC <= jump_target_D, push NPC_D, kill=1.
  4. jump_D: PC <= jump_target_D, kill=1.
  5. branch_taken_D: PC <= branch_target_D, kill=1.
  6. No redirect: PC <= PC+1, kill=0.
- Redirect latency: redirect seen in cycle N gives PC=target at N+1. The instruction fetched in cycle N is killed at the N+1 edge. One bubble per redirect.
- kill is combinational from the D-stage inputs, stall and state.
- HALT: PC frozen, kill=1, disable_IR=0 (NOPs stream into IF_ID), all inputs ignored. Exits only via rst.
- RAS:
  - Circular buffer with pointer and count (0..RAS_DEPTH).
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH; ras_overflow<=1.
  - Pop when empty: target=RESET_PC, count stays 0, ras_underflow<=1.
  - Push and pop never occur together (priority above). Pointer wraps modulo RAS_DEPTH.
- Sticky flags clear only on rst.
- All arithmetic is unsigned and modulo 2^PC_W: PC=all-ones sequential gives PC=0.

Decomposition:
- Shared package (pipe_pkg): PC_W, RESET_PC, NOP_INSTR=32'h00000000, fetch state enum {RUN, HALT}.
- Sub-module: return_address_stack (push, pop, push_data, top, full, empty, overflow/underflow pulses); synchronous rst.
- PC/next-PC mux and FSM stay in fetch_stage.

Test Plan:
- Reset then 4 free-run cycles, no redirects -> imem_addr 0,1,2,3; NPC_F 1,2,3,4; kill=0; disable_IR=0.
- PC=5, branch_taken_D=1, target=0x40 -> kill=1 that cycle; next imem_addr=0x40; next cycle PC=0x41.
- stall=1 with jump_D=1 (target 0x80) at PC=7 -> PC stays 7, disable_IR=1, kill=0. Drop stall with jump still asserted -> PC=0x80.
- call_D pushes NPC_D=0x11, 0x22, then ret_D twice -> PCs 0x22 then 0x11. A third ret_D -> PC=RESET_PC, ras_underflow=1.
- RAS_DEPTH+1 calls (NPC_D 1..9), then 8 rets -> returns 9..2, ras_overflow=1. The 9th ret underflows.
- halt_D at PC=3 -> kill stays 1 and PC stays 3 through 5 cycles with branch/jump toggling. rst -> PC=RESET_PC, state RUN, flags 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and fetch state type
package pipe_pkg;

  localparam int          PC_W      = 32;
  localparam logic [31:0] RESET_PC  = 32'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - circular return address stack with overflow/underflow pulses
module return_address_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         overflow,
  output logic         underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   count;

  // ptr is the next free slot; when full it also names the oldest entry,
  // so a push while full overwrites exactly that entry.
  assign top_idx   = ptr - PTR_W'(1);
  assign top       = mem[top_idx];
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign overflow  = push & full;
  assign underflow = pop & ~push & empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, redirect mux, RAS and RUN/HALT control
module fetch_stage #(
  parameter int              PC_W      = pipe_pkg::PC_W,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(pipe_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken_D,
  input  logic [PC_W-1:0] branch_target_D,
  input  logic            jump_D,
  input  logic            call_D,
  input  logic [PC_W-1:0] jump_target_D,
  input  logic            ret_D,
  input  logic [PC_W-1:0] NPC_D,
  input  logic            halt_D,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [31:0]     Instruction_F,
  output logic [PC_W-1:0] NPC_F,
  output logic            kill,
  output logic            disable_IR,
  output logic            ras_overflow,
  output logic            ras_underflow
);
  import pipe_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty, ras_full_unused;
  logic            ras_ovf_pulse, ras_unf_pulse;

  assign imem_addr     = pc_q;
  assign Instruction_F = imem_data;
  assign NPC_F         = pc_q + PC_W'(1);

  return_address_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (PC_W)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(NPC_D),
    .top      (ras_top),
    .full     (ras_full_unused),
    .empty    (ras_empty),
    .overflow (ras_ovf_pulse),
    .underflow(ras_unf_pulse)
  );

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    kill       = 1'b0;
    disable_IR = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    if (rst) begin
      kill = 1'b1;
    end else if (state_q == HALT) begin
      kill = 1'b1;
    end else if (stall) begin
      // ID re-presents the same instruction next cycle, so its redirect waits
      disable_IR = 1'b1;
    end else if (halt_D) begin
      kill    = 1'b1;
      state_d = HALT;
    end else if (ret_D) begin
      kill    = 1'b1;
      ras_pop = 1'b1;
      pc_d    = ras_empty ? RESET_PC : ras_top;
    end else if (call_D) begin
      kill     = 1'b1;
      ras_push = 1'b1;
      pc_d     = jump_target_D;
    end else if (jump_D) begin
      kill = 1'b1;
      pc_d = jump_target_D;
    end else if (branch_taken_D) begin
      kill = 1'b1;
      pc_d = branch_target_D;
    end else begin
      pc_d = NPC_F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ras_overflow  <= ras_overflow | ras_ovf_pulse;
      ras_underflow <= ras_underflow | ras_unf_pulse;
    end
  end

endmodule
